keypad_lock_controller: RTL and testbench
=========================================

# keypad_lock_controller

Clocked, parametrised successor to the combinational smart lock in the home-automation security group. It validates keypad entries against a main code and an optional temporary code. It counts consecutive failed attempts, enters a timed lockout after too many failures, and re-locks automatically after an unlock timeout. It sits between the keypad/remote front end and the lock actuator, and drives the security alert path.

## Interface
- CODE_W, 4: keypad/code width in bits
- MAIN_CODE, 4'b1010: fixed main access code (CODE_W bits)
- MAX_TRIES, 3: consecutive failures that trigger lockout (≥1)
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles (≥1)
- RELOCK_CYCLES, 8: auto-relock timeout in clk cycles (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- code_valid  in  1  one-cycle strobe: keypad holds a complete entry
- keypad  in  CODE_W  entered code, sampled only when code_valid=1
- temp_code  in  CODE_W  temporary access code
- temp_code_en  in  1  1 = temp_code is accepted
- remote_unlock  in  1  remote unlock request (level, sampled each cycle)
- remote_lock  in  1  remote lock request (level, sampled each cycle)
- lock_state  out  1  0 = locked, 1 = unlocked
- lockout  out  1  1 while in LOCKOUT
- alert  out  1  one-cycle pulse on lockout entry
- fail_count  out  $clog2(MAX_TRIES+1)  current consecutive failure count

## Operation
- FSM states:
  - LOCKED (reset state)
  - UNLOCKED
  - LOCKOUT
- Match condition: keypad==MAIN_CODE, or (temp_code_en and keypad==temp_code).
- Input priority within a cycle: remote_lock > remote_unlock > code_valid.
- LOCKED:
  - remote_lock: stay in LOCKED.
  - remote_unlock: go to UNLOCKED; fail_count←0.
  - code_valid with match: go to UNLOCKED; fail_count←0.
  - code_valid with mismatch: fail_count+1.
  - If the increment reaches MAX_TRIES: go to LOCKOUT, fail_count←0, alert pulses.
- UNLOCKED:
  - remote_lock: go to LOCKED.
  - Relock timer expiry: go to LOCKED.
  - code_valid with match, or remote_unlock: restart the relock timer.
  - code_valid with mismatch: ignored; not counted.
- LOCKOUT:
  - code_valid: ignored; no counting.
  - remote_lock: no effect.
  - remote_unlock: go to UNLOCKED; the owner override is honoured.
  - Lockout timer expiry: go to LOCKED; fail_count stays 0.
- fail_count saturates logically: it can never be observed equal to MAX_TRIES.
- fail_count is cleared on every successful unlock, by code or remote.
- Timer: a single down-counter shared by UNLOCKED and LOCKOUT.
  - Width: $clog2(max(LOCKOUT_CYCLES,RELOCK_CYCLES)+1).
  - Loaded on state entry or restart; decrements each cycle.
  - Expiry occurs when it reaches 1 while counting.
- Equality compares use full CODE_W bits. No partial or X matching.

## Timing
- All outputs are registered. An input sampled at edge N takes effect on the outputs after edge N (1-cycle latency).
- Reset values while rst_n=0 at an edge: state LOCKED, lock_state=0, lockout=0, alert=0, fail_count=0, timer=0.
- Reset mid-UNLOCKED or mid-LOCKOUT aborts the state immediately. There is no residual timer.
- UNLOCKED entered at edge N holds lock_state=1 for exactly RELOCK_CYCLES cycles; lock_state=0 after edge N+RELOCK_CYCLES, absent restart or remote_lock.
- LOCKOUT entered at edge N holds lockout=1 for exactly LOCKOUT_CYCLES cycles.
- alert=1 only in the cycle immediately after the lockout-entering edge.
- Restart on the same edge as expiry: the restart wins and the state stays UNLOCKED.
- remote_lock and remote_unlock high together: treated as lock.
- A code_valid held high for several cycles counts as one entry per cycle. The upstream front end must pulse it.

## Structure
- Package keypad_lock_pkg:
  - State enum (LOCKED, UNLOCKED, LOCKOUT).
  - Constants LOCK_LOCKED=1'b0, LOCK_UNLOCKED=1'b1.
- Sub-module lock_timer:
  - Parametrised width down-counter.
  - Inputs: load, load_value, enable.
  - Output: expire.
  - Instantiated once in the top block.
- Top block contains the FSM, the match compare and the fail counter.

## Test plan
- Reset, then code_valid with keypad=4'b1010 → lock_state=1 one cycle later. lock_state=0 exactly 8 cycles after entry.
- temp_code=4'b0011, temp_code_en=0, keypad=4'b0011 → fail_count=1, stays locked. Repeat with temp_code_en=1 → unlocks.
- Three consecutive wrong entries (4'b0000) → fail_count goes 1, 2, then lockout=1 with a 1-cycle alert and fail_count=0. Correct code during the 16-cycle lockout is ignored. Back to LOCKED after 16 cycles.
- Two wrong entries, then the correct code → unlock with fail_count=0. One further wrong entry after relock gives fail_count=1, not lockout.
- In UNLOCKED, correct code at cycle 5 of 8 → the timer restarts for a full 8 cycles. remote_lock and remote_unlock asserted together → locks next cycle.
- remote_unlock during LOCKOUT → UNLOCKED, lockout=0. rst_n=0 mid-UNLOCKED → all outputs at reset values after that edge.

Source files
------------

// File: rtl/keypad_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_lock_pkg
// Purpose  : Shared types and constants for the keypad lock controller:
//            FSM state encoding, lock_state output encoding and a small
//            helper used to size the shared timer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } lock_fsm_e;

  localparam logic LOCK_LOCKED   = 1'b0;
  localparam logic LOCK_UNLOCKED = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_lock_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_lock_controller_if
// Purpose  : Bundles the keypad/remote request signals and the lock status
//            outputs of the keypad lock controller.
// Ports    : master - front end (drives requests, observes status)
//            slave  - controller (observes requests, drives status)
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_lock_controller_if #(
  parameter int CODE_W    = 4,
  parameter int MAX_TRIES = 3
);
  import keypad_lock_pkg::*;

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  logic              code_valid;
  logic [CODE_W-1:0] keypad;
  logic [CODE_W-1:0] temp_code;
  logic              temp_code_en;
  logic              remote_unlock;
  logic              remote_lock;
  logic              lock_state;
  logic              lockout;
  logic              alert;
  logic [FAIL_W-1:0] fail_count;

  modport master (
    output code_valid, keypad, temp_code, temp_code_en, remote_unlock, remote_lock,
    input  lock_state, lockout, alert, fail_count
  );

  modport slave (
    input  code_valid, keypad, temp_code, temp_code_en, remote_unlock, remote_lock,
    output lock_state, lockout, alert, fail_count
  );

endinterface
`default_nettype wire

// File: rtl/keypad_lock_controller_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer
// Purpose  : Loadable down-counter shared by the relock and lockout phases.
//            expire is asserted while enabled and the count is 1, i.e. on
//            the final cycle of the loaded interval.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            load, load_value    - load request and value (load has priority)
//            enable              - count down while high
//            expire              - interval ends at the coming edge
// Revision : 1.0 - initial release
// ============================================================================
module lock_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/keypad_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : keypad_lock_controller
// Purpose  : Keypad lock FSM. Validates entries against a main code and an
//            optional temporary code, counts consecutive failures, enters a
//            timed lockout after MAX_TRIES failures and auto-relocks after
//            RELOCK_CYCLES in the unlocked state.
// Ports    : clk, rst_n - clock, synchronous active-low reset
//            bus        - slave side of keypad_lock_controller_if
//                         (requests in; lock_state/lockout/alert/fail_count out)
// Revision : 1.0 - initial release
// ============================================================================
module keypad_lock_controller
  import keypad_lock_pkg::*;
#(
  parameter int              CODE_W         = 4,
  parameter logic [CODE_W-1:0] MAIN_CODE    = 4'b1010,
  parameter int              MAX_TRIES      = 3,
  parameter int              LOCKOUT_CYCLES = 16,
  parameter int              RELOCK_CYCLES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  keypad_lock_controller_if.slave bus
);

  localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
  localparam int TIMER_W = $clog2(max_u(LOCKOUT_CYCLES, RELOCK_CYCLES) + 1);

  lock_fsm_e         state;
  logic              lock_state;
  logic              lockout;
  logic              alert;
  logic [FAIL_W-1:0] fail_count;

  logic               match;
  logic [FAIL_W-1:0]  fail_inc;
  logic               unlock_req;
  logic               code_ok;
  logic               code_bad;
  logic               to_unlocked;
  logic               restart;
  logic               to_lockout;
  logic               relock;
  logic               lockout_done;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_en;
  logic               expire;

  // Decision logic. remote_lock masks everything below it, remote_unlock
  // masks keypad entries, so each decision already reflects the priority.
  always_comb begin
    match        = (bus.keypad == MAIN_CODE) ||
                   (bus.temp_code_en && (bus.keypad == bus.temp_code));
    fail_inc     = fail_count + 1'b1;
    unlock_req   = !bus.remote_lock && bus.remote_unlock;
    code_ok      = !bus.remote_lock && !bus.remote_unlock && bus.code_valid && match;
    code_bad     = !bus.remote_lock && !bus.remote_unlock && bus.code_valid && !match;

    to_unlocked  = ((state == LOCKED) && (unlock_req || code_ok)) ||
                   ((state == LOCKOUT) && unlock_req);
    restart      = (state == UNLOCKED) && (unlock_req || code_ok);
    to_lockout   = (state == LOCKED) && code_bad && (fail_inc == FAIL_W'(MAX_TRIES));
    // Restart beats expiry on the same edge.
    relock       = (state == UNLOCKED) && (bus.remote_lock || (expire && !restart));
    // remote_lock has no effect in lockout, so expiry still proceeds.
    lockout_done = (state == LOCKOUT) && expire && !unlock_req;

    // Early relock by remote loads zero so no stale count is left behind.
    timer_load   = to_unlocked || restart || to_lockout || relock;
    timer_value  = '0;
    if (to_lockout) begin
      timer_value = TIMER_W'(LOCKOUT_CYCLES);
    end else if (to_unlocked || restart) begin
      timer_value = TIMER_W'(RELOCK_CYCLES);
    end
    timer_en     = (state != LOCKED);
  end

  lock_timer #(
    .WIDTH (TIMER_W)
  ) u_lock_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_en),
    .expire     (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOCKED;
      lock_state <= LOCK_LOCKED;
      lockout    <= 1'b0;
      alert      <= 1'b0;
      fail_count <= '0;
    end else begin
      alert <= to_lockout;
      if (to_unlocked || restart) begin
        state      <= UNLOCKED;
        lock_state <= LOCK_UNLOCKED;
        lockout    <= 1'b0;
        fail_count <= '0;
      end else if (to_lockout) begin
        state      <= LOCKOUT;
        lock_state <= LOCK_LOCKED;
        lockout    <= 1'b1;
        fail_count <= '0;
      end else if (relock || lockout_done) begin
        state      <= LOCKED;
        lock_state <= LOCK_LOCKED;
        lockout    <= 1'b0;
      end else if ((state == LOCKED) && code_bad) begin
        fail_count <= fail_inc;
      end
    end
  end

  assign bus.lock_state = lock_state;
  assign bus.lockout    = lockout;
  assign bus.alert      = alert;
  assign bus.fail_count = fail_count;

endmodule
`default_nettype wire

// File: tb/tb_keypad_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_lock_controller
// Purpose  : Directed self-checking bench for keypad_lock_controller.
//            Expected outputs are queued when each step is driven and
//            popped/compared one cycle later.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_lock_controller;

  logic clk;
  logic rst_n;

  keypad_lock_controller_if #(.CODE_W(4), .MAX_TRIES(3)) bus ();

  keypad_lock_controller #(
    .CODE_W         (4),
    .MAIN_CODE      (4'b1010),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (16),
    .RELOCK_CYCLES  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       ls;
    logic       lo;
    logic       al;
    logic [1:0] fc;
  } exp_t;

  exp_t sb[$];
  int   evaluated = 0;
  int   failures  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input string field, input logic obs, input logic exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s %s observed=%0b expected=%0b", tag, field, obs, exp);
    end
  endtask

  // One clock step: queue the expectation, let the edge happen, then compare.
  task automatic step(input string tag, input logic ls, input logic lo,
                      input logic al, input logic [1:0] fc);
    exp_t e;
    exp_t got;
    e.ls = ls; e.lo = lo; e.al = al; e.fc = fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk1(tag, "lock_state", bus.lock_state, got.ls);
    chk1(tag, "lockout",    bus.lockout,    got.lo);
    chk1(tag, "alert",      bus.alert,      got.al);
    evaluated++;
    assert (bus.fail_count === got.fc) else begin
      failures++;
      $error("FAIL %s fail_count observed=%0d expected=%0d", tag, bus.fail_count, got.fc);
    end
    bus.code_valid = 1'b0;
  endtask

  task automatic idle(input int n, input string tag, input logic ls, input logic lo,
                      input logic [1:0] fc);
    for (int i = 0; i < n; i++) step(tag, ls, lo, 1'b0, fc);
  endtask

  task automatic enter(input logic [3:0] code);
    bus.code_valid = 1'b1;
    bus.keypad     = code;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.code_valid    = 1'b0;
    bus.keypad        = 4'b0000;
    bus.temp_code     = 4'b0011;
    bus.temp_code_en  = 1'b0;
    bus.remote_unlock = 1'b0;
    bus.remote_lock   = 1'b0;
    #1;

    // Reset state
    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Main code unlock and auto-relock after exactly 8 cycles
    enter(4'b1010);
    step("main_unlock", 1, 0, 0, 0);
    idle(7, "relock_hold", 1, 0, 0);
    step("relock_edge", 0, 0, 0, 0);

    // Temporary code: rejected when disabled, accepted when enabled
    bus.temp_code_en = 1'b0;
    enter(4'b0011);
    step("temp_disabled", 0, 0, 0, 1);
    bus.temp_code_en = 1'b1;
    enter(4'b0011);
    step("temp_enabled", 1, 0, 0, 0);
    bus.temp_code_en = 1'b0;
    bus.remote_lock  = 1'b1;
    step("remote_lock", 0, 0, 0, 0);
    bus.remote_lock  = 1'b0;

    // Three failures -> lockout with one-cycle alert; keypad ignored
    enter(4'b0000);
    step("fail1", 0, 0, 0, 1);
    enter(4'b0000);
    step("fail2", 0, 0, 0, 2);
    enter(4'b0000);
    step("lockout_entry", 0, 1, 1, 0);
    enter(4'b1010);
    step("lockout_code_ignored", 0, 1, 0, 0);
    idle(14, "lockout_hold", 0, 1, 0);
    step("lockout_expire", 0, 0, 0, 0);

    // Two failures then correct code clears the count
    enter(4'b0000);
    step("fail_a1", 0, 0, 0, 1);
    enter(4'b0000);
    step("fail_a2", 0, 0, 0, 2);
    enter(4'b1010);
    step("clear_on_unlock", 1, 0, 0, 0);
    idle(7, "relock_hold2", 1, 0, 0);
    step("relock_edge2", 0, 0, 0, 0);
    enter(4'b0000);
    step("fail_after_clear", 0, 0, 0, 1);

    // Correct code at cycle 5 of 8 restarts a full interval
    enter(4'b1010);
    step("unlock_p", 1, 0, 0, 0);
    idle(4, "pre_restart", 1, 0, 0);
    enter(4'b1010);
    step("restart_code", 1, 0, 0, 0);
    idle(7, "post_restart", 1, 0, 0);
    step("restart_relock", 0, 0, 0, 0);

    // Both remotes high is a lock
    bus.remote_unlock = 1'b1;
    step("remote_unlock", 1, 0, 0, 0);
    bus.remote_lock   = 1'b1;
    step("both_remotes", 0, 0, 0, 0);
    bus.remote_lock   = 1'b0;

    // Restart on the expiry edge wins
    step("remote_unlock_q", 1, 0, 0, 0);
    bus.remote_unlock = 1'b0;
    idle(7, "q_hold", 1, 0, 0);
    bus.remote_unlock = 1'b1;
    step("restart_at_expiry", 1, 0, 0, 0);
    bus.remote_unlock = 1'b0;
    idle(7, "q_hold2", 1, 0, 0);
    step("q_relock", 0, 0, 0, 0);

    // Remote unlock overrides lockout
    enter(4'b0000);
    step("fail_b1", 0, 0, 0, 1);
    enter(4'b0000);
    step("fail_b2", 0, 0, 0, 2);
    enter(4'b0000);
    step("lockout_b", 0, 1, 1, 0);
    bus.remote_unlock = 1'b1;
    step("override_lockout", 1, 0, 0, 0);
    bus.remote_unlock = 1'b0;
    idle(2, "unlocked_pre_reset", 1, 0, 0);

    // Reset mid-UNLOCKED aborts immediately with no residual timer
    rst_n = 1'b0;
    step("reset_mid_unlocked", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(9, "post_reset_locked", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
`default_nettype wire
